// File: rtl/flush_ctrl.sv
// flush_ctrl: commit-time trap / ertn / interrupt sequencer.
// Detects an event at WB while IDLE, latches it, drives a FLUSH_CYCLES-long
// pipeline flush with a single CSR update pulse in the first flush cycle,
// then holds a redirect PC toward IF until IF accepts it.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   wb_valid/ex/ertn         WB instruction status (ex/ertn qualified by valid)
//   wb_ecode/esubcode/pc     WB exception info
//   int_pending              enabled, pending interrupt from CSR
//   csr_eentry, csr_era      trap entry and return addresses
//   if_redirect_ready        IF accepts the redirect this cycle
//   wb_cancel                combinational: suppress WB rf write this cycle
//   flush                    flush all pipeline stages
//   csr_ex_we + csr_ex_*     one-cycle exception record pulse with payload
//   csr_ertn_we              one-cycle PRMD->CRMD restore pulse
//   redirect_valid/pc        fetch redirect toward IF
//   ctrl_busy                controller is not IDLE
module flush_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [5:0]  INT_ECODE    = 6'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_ex,
    input  logic        wb_ertn,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        int_pending,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    input  logic        if_redirect_ready,
    output logic        wb_cancel,
    output logic        flush,
    output logic        csr_ex_we,
    output logic [5:0]  csr_ex_ecode,
    output logic [8:0]  csr_ex_esubcode,
    output logic [31:0] csr_ex_era,
    output logic        csr_ertn_we,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        ctrl_busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        flush_d;
    logic        csr_ex_we_d;
    logic        csr_ertn_we_d;
    logic        redirect_valid_d;
    logic        ctrl_busy_d;
    logic [5:0]  ecode_d;
    logic [8:0]  esubcode_d;
    logic [31:0] era_d;
    logic [31:0] redirect_pc_d;

    logic is_idle;
    logic evt_int;
    logic evt_ex;
    logic evt_ertn;
    logic evt_any;

    // Event decode in priority order INT > EX > ERTN.
    assign is_idle  = (state_q == S_IDLE);
    assign evt_int  = wb_valid & int_pending;
    assign evt_ex   = wb_valid & ~int_pending & wb_ex;
    assign evt_ertn = wb_valid & ~int_pending & ~wb_ex & wb_ertn;
    assign evt_any  = evt_int | evt_ex | evt_ertn;

    // Ertn has no rf write, so only traps (incl. interrupt-converted) cancel.
    assign wb_cancel = is_idle & wb_valid & (int_pending | wb_ex);

    // Next-state and next-output logic; registered outputs follow state_d.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        csr_ex_we_d   = 1'b0;
        csr_ertn_we_d = 1'b0;
        ecode_d       = csr_ex_ecode;
        esubcode_d    = csr_ex_esubcode;
        era_d         = csr_ex_era;
        redirect_pc_d = redirect_pc;

        case (state_q)
            S_IDLE: begin
                if (evt_any) begin
                    state_d       = S_FLUSH;
                    cnt_d         = CNT_W'(FLUSH_CYCLES - 1);
                    redirect_pc_d = evt_ertn ? csr_era : csr_eentry;
                    if (evt_ertn) begin
                        csr_ertn_we_d = 1'b1;
                    end else begin
                        csr_ex_we_d = 1'b1;
                        ecode_d     = evt_int ? INT_ECODE : wb_ecode;
                        esubcode_d  = evt_int ? 9'd0 : wb_esubcode;
                        era_d       = wb_pc;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_REDIRECT: begin
                if (if_redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        flush_d          = (state_d == S_FLUSH);
        redirect_valid_d = (state_d == S_REDIRECT);
        ctrl_busy_d      = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            flush           <= 1'b0;
            csr_ex_we       <= 1'b0;
            csr_ertn_we     <= 1'b0;
            csr_ex_ecode    <= '0;
            csr_ex_esubcode <= '0;
            csr_ex_era      <= '0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            ctrl_busy       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            flush           <= flush_d;
            csr_ex_we       <= csr_ex_we_d;
            csr_ertn_we     <= csr_ertn_we_d;
            csr_ex_ecode    <= ecode_d;
            csr_ex_esubcode <= esubcode_d;
            csr_ex_era      <= era_d;
            redirect_valid  <= redirect_valid_d;
            redirect_pc     <= redirect_pc_d;
            ctrl_busy       <= ctrl_busy_d;
        end
    end

endmodule

// File: tb/tb_flush_ctrl.sv
// Bench for flush_ctrl: two instances (FLUSH_CYCLES = 1 and 3) share stimulus.
// A cycle-indexed reference model pushes expected CSR pulses and redirects
// into per-instance queues; a separate monitor pops them when the DUT shows
// a pulse or a consumed redirect.
module tb_flush_ctrl;

    localparam logic [5:0] INT_EC = 6'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_ex, wb_ertn, int_pending, if_redirect_ready;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, csr_eentry, csr_era;

    logic        cancel_o [2];
    logic        flush_o  [2];
    logic        exwe_o   [2];
    logic        ertnwe_o [2];
    logic        rv_o     [2];
    logic        busy_o   [2];
    logic [5:0]  ecode_o  [2];
    logic [8:0]  esub_o   [2];
    logic [31:0] era_o    [2];
    logic [31:0] rpc_o    [2];

    always #5 clk = ~clk;

    flush_ctrl #(.FLUSH_CYCLES(1), .INT_ECODE(INT_EC)) u_dut_fc1 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_ertn(wb_ertn),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .int_pending(int_pending), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .if_redirect_ready(if_redirect_ready), .wb_cancel(cancel_o[0]), .flush(flush_o[0]),
        .csr_ex_we(exwe_o[0]), .csr_ex_ecode(ecode_o[0]), .csr_ex_esubcode(esub_o[0]),
        .csr_ex_era(era_o[0]), .csr_ertn_we(ertnwe_o[0]), .redirect_valid(rv_o[0]),
        .redirect_pc(rpc_o[0]), .ctrl_busy(busy_o[0])
    );

    flush_ctrl #(.FLUSH_CYCLES(3), .INT_ECODE(INT_EC)) u_dut_fc3 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_ertn(wb_ertn),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .int_pending(int_pending), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .if_redirect_ready(if_redirect_ready), .wb_cancel(cancel_o[1]), .flush(flush_o[1]),
        .csr_ex_we(exwe_o[1]), .csr_ex_ecode(ecode_o[1]), .csr_ex_esubcode(esub_o[1]),
        .csr_ex_era(era_o[1]), .csr_ertn_we(ertnwe_o[1]), .redirect_valid(rv_o[1]),
        .redirect_pc(rpc_o[1]), .ctrl_busy(busy_o[1])
    );

    typedef struct {
        int          cyc;
        bit          ertn;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] era;
    } csr_exp_t;

    typedef struct {
        int          earliest;
        logic [31:0] pc;
    } rdr_exp_t;

    csr_exp_t csr_q [2][$];
    rdr_exp_t rdr_q [2][$];

    bit m_busy [2];
    int m_acc  [2];
    bit m_ertn [2];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fc_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s fc=%0d cyc=%0d got=%0h exp=%0h", nm, fc_of(inst), cyc, act, exp);
        end
    endtask

    // Monitor: pop expectations when a DUT presents a pulse or a redirect.
    always @(negedge clk) begin
        csr_exp_t e;
        rdr_exp_t r;
        #2;
        for (int i = 0; i < 2; i++) begin
            if (exwe_o[i] === 1'b1 || ertnwe_o[i] === 1'b1) begin
                if (csr_q[i].size() == 0) begin
                    check("csr_pulse_unexpected", i, 32'd1, 32'd0);
                end else begin
                    e = csr_q[i].pop_front();
                    check("csr_pulse_cycle", i, 32'(cyc), 32'(e.cyc));
                    check("csr_ertn_we", i, 32'(ertnwe_o[i]), 32'(e.ertn));
                    check("csr_ex_we", i, 32'(exwe_o[i]), 32'(!e.ertn));
                    if (!e.ertn) begin
                        check("csr_ex_ecode", i, 32'(ecode_o[i]), 32'(e.ecode));
                        check("csr_ex_esubcode", i, 32'(esub_o[i]), 32'(e.esub));
                        check("csr_ex_era", i, era_o[i], e.era);
                    end
                end
            end
            if (rv_o[i] === 1'b1) begin
                if (rdr_q[i].size() == 0) begin
                    check("redirect_unexpected", i, 32'd1, 32'd0);
                end else begin
                    check("redirect_pc", i, rpc_o[i], rdr_q[i][0].pc);
                    if (if_redirect_ready) begin
                        r = rdr_q[i].pop_front();
                        check("redirect_not_early", i, 32'(cyc >= r.earliest), 32'd1);
                    end
                end
            end
        end
    end

    // Reference model: per-cycle expectations from the accept cycle arithmetic.
    always @(negedge clk) begin
        int fc;
        bit e_flush, e_rv, e_cancel, e_exwe, e_ertnwe;
        #3;
        for (int i = 0; i < 2; i++) begin
            fc       = fc_of(i);
            e_flush  = m_busy[i] && (cyc <= m_acc[i] + fc);
            e_rv     = m_busy[i] && (cyc > m_acc[i] + fc);
            e_cancel = !m_busy[i] && wb_valid && (int_pending || wb_ex);
            e_exwe   = m_busy[i] && (cyc == m_acc[i] + 1) && !m_ertn[i];
            e_ertnwe = m_busy[i] && (cyc == m_acc[i] + 1) && m_ertn[i];
            check("flush", i, 32'(flush_o[i]), 32'(e_flush));
            check("redirect_valid", i, 32'(rv_o[i]), 32'(e_rv));
            check("ctrl_busy", i, 32'(busy_o[i]), 32'(m_busy[i]));
            check("wb_cancel", i, 32'(cancel_o[i]), 32'(e_cancel));
            check("csr_ex_we_cycle", i, 32'(exwe_o[i]), 32'(e_exwe));
            check("csr_ertn_we_cycle", i, 32'(ertnwe_o[i]), 32'(e_ertnwe));

            if (reset) begin
                m_busy[i] = 1'b0;
                csr_q[i].delete();
                rdr_q[i].delete();
            end else if (!m_busy[i] && wb_valid && (int_pending || wb_ex || wb_ertn)) begin
                m_busy[i] = 1'b1;
                m_acc[i]  = cyc;
                m_ertn[i] = !int_pending && !wb_ex;
                csr_q[i].push_back('{cyc: cyc + 1, ertn: m_ertn[i],
                                     ecode: int_pending ? INT_EC : wb_ecode,
                                     esub: int_pending ? 9'd0 : wb_esubcode,
                                     era: wb_pc});
                rdr_q[i].push_back('{earliest: cyc + fc + 1,
                                     pc: m_ertn[i] ? csr_era : csr_eentry});
            end else if (m_busy[i] && (cyc > m_acc[i] + fc) && if_redirect_ready) begin
                m_busy[i] = 1'b0;
            end
        end
    end

    task automatic drive(input bit v, input bit ex, input bit ertn, input bit intp,
                         input logic [5:0] ec, input logic [8:0] es, input logic [31:0] pc,
                         input logic [31:0] eentry, input logic [31:0] era,
                         input bit rdy, input bit rst);
        @(negedge clk);
        wb_valid          = v;
        wb_ex             = ex;
        wb_ertn           = ertn;
        int_pending       = intp;
        wb_ecode          = ec;
        wb_esubcode       = es;
        wb_pc             = pc;
        csr_eentry        = eentry;
        csr_era           = era;
        if_redirect_ready = rdy;
        reset             = rst;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h3F, 9'h1FF, 32'hDEAD_0000,
              32'h1C00_8000, 32'h1C00_0204, rdy, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy[0] || m_busy[1]) && n < 60) begin
            idle(1'b1);
            n++;
        end
        if (n >= 60) check("idle_timeout", 0, 32'd1, 32'd0);
    endtask

    // Registered outputs after a reset cycle must all be zero.
    task automatic check_zero();
        #4;
        for (int i = 0; i < 2; i++) begin
            check("rst_csr_ex_ecode", i, 32'(ecode_o[i]), 32'd0);
            check("rst_csr_ex_esubcode", i, 32'(esub_o[i]), 32'd0);
            check("rst_csr_ex_era", i, era_o[i], 32'd0);
            check("rst_redirect_pc", i, rpc_o[i], 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        wb_valid = 1'b0; wb_ex = 1'b0; wb_ertn = 1'b0; int_pending = 1'b0;
        wb_ecode = '0; wb_esubcode = '0; wb_pc = '0;
        csr_eentry = '0; csr_era = '0; if_redirect_ready = 1'b0;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(1'b0);
        check_zero();

        // EX only
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'h0B, 9'h0, 32'h1C00_0100,
              32'h1C00_8000, 32'h1C00_0204, 1'b1, 1'b0);
        wait_idle();
        // ERTN
        drive(1'b1, 1'b0, 1'b1, 1'b0, 6'h0B, 9'h0, 32'h1C00_0200,
              32'h1C00_8000, 32'h1C00_0204, 1'b1, 1'b0);
        wait_idle();
        // Interrupt over EX
        drive(1'b1, 1'b1, 1'b0, 1'b1, 6'h0B, 9'h5, 32'h1C00_0300,
              32'h1C00_8000, 32'h1C00_0204, 1'b1, 1'b0);
        wait_idle();

        // IF backpressure, wrong-path EX pulses at T+2 and T+5
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'h0C, 9'h3, 32'h1C00_0400,
              32'h1C00_9000, 32'h1C00_0204, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            drive((k == 2 || k == 5), (k == 2 || k == 5), 1'b0, 1'b0, 6'h0D, 9'h7,
                  32'h1C00_0500 + 32'(k), 32'h1C00_A000, 32'h1C00_0600, (k == 8), 1'b0);
        end
        wait_idle();
        idle(1'b1);

        // Reset mid-FLUSH, then a fresh EX at T+4
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'h0E, 9'h2, 32'h1C00_0700,
              32'h1C00_B000, 32'h1C00_0204, 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(1'b0);
        check_zero();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'h0F, 9'h4, 32'h1C00_0800,
              32'h1C00_C000, 32'h1C00_0204, 1'b1, 1'b0);
        wait_idle();

        // wb_valid low: no event
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 6'h0B, 9'h1, 32'h1C00_0900,
                  32'h1C00_8000, 32'h1C00_0204, 1'b1, 1'b0);
        end

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                  6'($urandom), 9'($urandom), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 4) < 3), ($urandom_range(0, 63) == 0));
        end
        wait_idle();
        idle(1'b1);
        idle(1'b1);
        #4;
        for (int i = 0; i < 2; i++) begin
            check("csr_q_drained", i, 32'(csr_q[i].size()), 32'd0);
            check("rdr_q_drained", i, 32'(rdr_q[i].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
